// File: rtl/enc_pkg.sv
// enc_pkg: shared constants for the RV32I instruction encoder.
//   - FMT_R..FMT_J : one-hot values of the i_format request field
//   - OP_*         : RV32I base opcodes
//   - IMM*_MIN/MAX : signed immediate limits checked when ENC_CHECK_EN is defined
//   - fmt_of_opcode: the instruction format a base opcode uses (FMT_NONE if unknown)
package enc_pkg;

    localparam logic [5:0] FMT_NONE = 6'b000000;
    localparam logic [5:0] FMT_R    = 6'b000001;
    localparam logic [5:0] FMT_I    = 6'b000010;
    localparam logic [5:0] FMT_S    = 6'b000100;
    localparam logic [5:0] FMT_B    = 6'b001000;
    localparam logic [5:0] FMT_U    = 6'b010000;
    localparam logic [5:0] FMT_J    = 6'b100000;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_OP     = 7'h33;

    localparam int signed IMM12_MIN = -2048;
    localparam int signed IMM12_MAX = 2047;
    localparam int signed IMMB_MIN  = -4096;
    localparam int signed IMMB_MAX  = 4094;
    localparam int signed IMMJ_MIN  = -1048576;
    localparam int signed IMMJ_MAX  = 1048574;

    function automatic logic [5:0] fmt_of_opcode(input logic [6:0] op);
        logic [5:0] f;
        f = FMT_NONE;
        case (op)
            OP_OP:                      f = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR:   f = FMT_I;
            OP_STORE:                   f = FMT_S;
            OP_BRANCH:                  f = FMT_B;
            OP_LUI, OP_AUIPC:           f = FMT_U;
            OP_JAL:                     f = FMT_J;
            default:                    f = FMT_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/enc_fifo.sv
// enc_fifo: DEPTH-entry synchronous FIFO (DEPTH a power of two, >= 2).
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset (empties the FIFO)
//   i_push, i_data : write i_data at the tail (ignored when full)
//   i_pop          : advance the head (ignored when empty)
//   o_data         : head word, zero while empty
//   o_count        : occupancy 0..DEPTH
//   o_full, o_empty: occupancy flags
module enc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign o_full  = (o_count == CW'(DEPTH));
    assign o_empty = (o_count == '0);
    assign do_push = i_push & ~o_full;
    assign do_pop  = i_pop & ~o_empty;

    // Storage is not reset; the pointers and count define which entries exist.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   o_count <= o_count + CW'(1);
                2'b01:   o_count <= o_count - CW'(1);
                default: o_count <= o_count;
            endcase
        end
    end

    // Head is forced to zero while empty so stale words never appear on the output.
    assign o_data = o_empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields into 32-bit instruction words and
// queues them in an output FIFO.
// Optional feature macro: ENC_CHECK_EN -- when defined, malformed requests
// (format not one-hot, immediate out of range or misaligned, U imm[11:0] != 0)
// are accepted but dropped and flagged on o_err. When undefined, immediates
// are truncated to their field, a zero-hot format yields the bare opcode, and
// o_err is tied low.
// Ports:
//   i_clk, i_rst_n      : clock, synchronous active-low reset
//   i_valid / o_ready   : request handshake (o_ready = FIFO not full)
//   i_format            : one-hot {J,U,B,S,I,R}
//   i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm : decoded fields
//   o_valid / i_ready   : output stream handshake, o_instr is the FIFO head
//   o_err               : one-cycle pulse after a dropped illegal request
//   o_count             : FIFO occupancy
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and its data stable until that edge;
// ready never depends on valid. The request side accepts iff the FIFO is not
// full at the edge (no pass-through when full); the output side pops iff the
// FIFO is non-empty and i_ready is high.
module instr_encoder
    import enc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [5:0]             i_format,
    input  logic [6:0]             i_opcode,
    input  logic [4:0]             i_rd,
    input  logic [4:0]             i_rs1,
    input  logic [4:0]             i_rs2,
    input  logic [2:0]             i_funct3,
    input  logic [6:0]             i_funct7,
    input  logic [31:0]            i_imm,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [31:0]            o_instr,
    output logic                   o_err,
    output logic [$clog2(DEPTH):0] o_count
);

    logic        accept;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] word;

    assign o_ready = ~fifo_full;
    assign o_valid = ~fifo_empty;
    assign accept  = i_valid & o_ready;
    assign pop     = o_valid & i_ready;

    // Each format contributes its packed fields only when its bit is set, so a
    // zero-hot format leaves just the opcode.
    always_comb begin
        word = {25'b0, i_opcode};
        if (|(i_format & FMT_R)) begin
            word = word | {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, 7'b0};
        end
        if (|(i_format & FMT_I)) begin
            word = word | {i_imm[11:0], i_rs1, i_funct3, i_rd, 7'b0};
        end
        if (|(i_format & FMT_S)) begin
            word = word | {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], 7'b0};
        end
        if (|(i_format & FMT_B)) begin
            word = word | {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                           i_imm[4:1], i_imm[11], 7'b0};
        end
        if (|(i_format & FMT_U)) begin
            word = word | {i_imm[31:12], i_rd, 7'b0};
        end
        if (|(i_format & FMT_J)) begin
            word = word | {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, 7'b0};
        end
    end

`ifdef ENC_CHECK_EN
    logic signed [31:0] imm_s;
    logic               legal;
    logic               err_q;

    assign imm_s = $signed(i_imm);

    always_comb begin
        legal = 1'b0;
        if ($onehot(i_format)) begin
            if (|(i_format & FMT_R)) begin
                legal = 1'b1;
            end else if (|(i_format & (FMT_I | FMT_S))) begin
                legal = (imm_s >= IMM12_MIN) && (imm_s <= IMM12_MAX);
            end else if (|(i_format & FMT_B)) begin
                legal = (imm_s >= IMMB_MIN) && (imm_s <= IMMB_MAX) && !i_imm[0];
            end else if (|(i_format & FMT_J)) begin
                legal = (imm_s >= IMMJ_MIN) && (imm_s <= IMMJ_MAX) && !i_imm[0];
            end else begin
                // U: the low 12 bits cannot be represented.
                legal = (i_imm[11:0] == 12'h000);
            end
        end
    end

    assign push = accept & legal;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept & ~legal;
        end
    end

    assign o_err = err_q;
`else
    assign push  = accept;
    assign o_err = 1'b0;
`endif

    enc_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_data  (word),
        .i_pop   (pop),
        .o_data  (o_instr),
        .o_count (o_count),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    localparam int DEPTH = 4;

    typedef struct {
        logic [5:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } req_t;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [5:0]  i_format;
    logic [6:0]  i_opcode;
    logic [4:0]  i_rd;
    logic [4:0]  i_rs1;
    logic [4:0]  i_rs2;
    logic [2:0]  i_funct3;
    logic [6:0]  i_funct7;
    logic [31:0] i_imm;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_instr;
    logic        o_err;
    logic [$clog2(DEPTH):0] o_count;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 0;

    // Scoreboard: words the FIFO must hold, head first.
    logic [31:0] exp_q[$];
    logic        exp_err = 1'b0;

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_format (i_format),
        .i_opcode (i_opcode),
        .i_rd     (i_rd),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_funct3 (i_funct3),
        .i_funct7 (i_funct7),
        .i_imm    (i_imm),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_instr  (o_instr),
        .o_err    (o_err),
        .o_count  (o_count)
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic apply_reset(input int cycles);
        @(negedge i_clk);
        #1 i_rst_n = 1'b0;
        repeat (cycles) @(posedge i_clk);
        #1 chk_en = 1'b1;
        @(negedge i_clk);
        #1 i_rst_n = 1'b1;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    endtask

    // Field slice of a value by plain shifting and masking.
    function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
        logic [31:0] mask;
        mask = (32'h1 << (hi - lo + 1)) - 32'h1;
        return (v >> lo) & mask;
    endfunction

    // Instruction word built field by field from the RV32I layout tables.
    function automatic logic [31:0] model_encode(input req_t r);
        logic [31:0] w;
        logic [31:0] regs;
        w = 32'(r.op);
        case (r.fmt)
            6'b000001: w = w + (32'(r.f7) << 25) + (32'(r.rs2) << 20) + (32'(r.rs1) << 15)
                             + (32'(r.f3) << 12) + (32'(r.rd) << 7);
            6'b000010: w = w + (fld(r.imm, 11, 0) << 20) + (32'(r.rs1) << 15)
                             + (32'(r.f3) << 12) + (32'(r.rd) << 7);
            6'b000100: w = w + (fld(r.imm, 11, 5) << 25) + (32'(r.rs2) << 20) + (32'(r.rs1) << 15)
                             + (32'(r.f3) << 12) + (fld(r.imm, 4, 0) << 7);
            6'b001000: begin
                regs = (32'(r.rs2) << 20) + (32'(r.rs1) << 15) + (32'(r.f3) << 12);
                w = w + regs + (fld(r.imm, 12, 12) << 31) + (fld(r.imm, 10, 5) << 25)
                      + (fld(r.imm, 4, 1) << 8) + (fld(r.imm, 11, 11) << 7);
            end
            6'b010000: w = w + (fld(r.imm, 31, 12) << 12) + (32'(r.rd) << 7);
            6'b100000: w = w + (fld(r.imm, 20, 20) << 31) + (fld(r.imm, 10, 1) << 21)
                             + (fld(r.imm, 11, 11) << 20) + (fld(r.imm, 19, 12) << 12)
                             + (32'(r.rd) << 7);
            default: w = 32'(r.op);
        endcase
        return w;
    endfunction

    function automatic bit model_legal(input req_t r);
`ifdef ENC_CHECK_EN
        int v;
        v = $signed(r.imm);
        case (r.fmt)
            6'b000001: return 1'b1;
            6'b000010,
            6'b000100: return (v >= -2048) && (v <= 2047);
            6'b001000: return (v >= -4096) && (v <= 4094) && (v % 2 == 0);
            6'b100000: return (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
            6'b010000: return (r.imm % 4096) == 0;
            default:   return 1'b0;
        endcase
`else
        return (r.fmt == r.fmt);
`endif
    endfunction

    // Reference behaviour updated at every active edge from the sampled inputs.
    always @(posedge i_clk) begin
        req_t cur;
        bit   acc;
        bit   pp;
        bit   ok;
        if (!i_rst_n) begin
            exp_q.delete();
            exp_err = 1'b0;
        end else begin
            cur = '{i_format, i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm};
            acc = i_valid && (exp_q.size() < DEPTH);
            pp  = (exp_q.size() > 0) && i_ready;
            ok  = model_legal(cur);
            if (pp) void'(exp_q.pop_front());
            if (acc && ok) exp_q.push_back(model_encode(cur));
            exp_err = acc && !ok;
        end
    end

    // Compare process: outputs against the scoreboard every cycle.
    always @(negedge i_clk) begin
        if (chk_en) begin
            check("count", 32'(o_count), 32'(exp_q.size()));
            check("valid", 32'(o_valid), 32'(exp_q.size() > 0));
            check("ready", 32'(o_ready), 32'(exp_q.size() < DEPTH));
            check("instr", o_instr, (exp_q.size() > 0) ? exp_q[0] : 32'h0);
            check("err",   32'(o_err), 32'(exp_err));
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input req_t r);
        bit done;
        done = 0;
        @(negedge i_clk);
        #1;
        i_format = r.fmt; i_opcode = r.op; i_rd = r.rd; i_rs1 = r.rs1;
        i_rs2 = r.rs2; i_funct3 = r.f3; i_funct7 = r.f7; i_imm = r.imm;
        i_valid = 1'b1;
        for (int k = 0; k < 64 && !done; k++) begin
            if (o_ready) begin
                @(posedge i_clk);
                done = 1;
            end else begin
                @(negedge i_clk);
                #1;
            end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL send_timeout: got no acceptance required acceptance within 64 cycles");
        end
    endtask

    task automatic idle();
        @(negedge i_clk);
        #1 i_valid = 1'b0;
    endtask

    // Checks the head against a hand-computed word, then pops it.
    task automatic pop_check(input string name, input logic [31:0] lit);
        @(negedge i_clk);
        check({name, "_valid"}, 32'(o_valid), 32'h1);
        check(name, o_instr, lit);
        #1 i_ready = 1'b1;
        @(posedge i_clk);
        #1 i_ready = 1'b0;
    endtask

    function automatic req_t mk(input logic [5:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] imm);
        req_t r;
        r = '{fmt, op, rd, rs1, rs2, f3, f7, imm};
        return r;
    endfunction

    req_t addi, add, sw, lui, beq, jal;
    req_t tbl[8];

    initial begin
        i_rst_n = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        i_format = '0; i_opcode = '0; i_rd = '0; i_rs1 = '0; i_rs2 = '0;
        i_funct3 = '0; i_funct7 = '0; i_imm = '0;

        addi = mk(6'b000010, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        add  = mk(6'b000001, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        sw   = mk(6'b000100, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        lui  = mk(6'b010000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        beq  = mk(6'b001000, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC);
        jal  = mk(6'b100000, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);

        tbl[0] = mk(6'b000001, 7'h33, 5'd7,  5'd8,  5'd9,  3'd0, 7'h20, 32'd0);          // SUB
        tbl[1] = mk(6'b000010, 7'h03, 5'd10, 5'd2,  5'd0,  3'd2, 7'd0,  32'hFFFFF800);   // LW -2048
        tbl[2] = mk(6'b000010, 7'h13, 5'd4,  5'd4,  5'd0,  3'd5, 7'd0,  32'h00000405);   // SRAI 5
        tbl[3] = mk(6'b001000, 7'h63, 5'd0,  5'd3,  5'd31, 3'd1, 7'd0,  32'd4094);       // BNE max
        tbl[4] = mk(6'b100000, 7'h6F, 5'd0,  5'd0,  5'd0,  3'd0, 7'd0,  32'hFFF00000);   // JAL min
        tbl[5] = mk(6'b010000, 7'h17, 5'd31, 5'd0,  5'd0,  3'd0, 7'd0,  32'hFFFFF000);   // AUIPC
        tbl[6] = mk(6'b000100, 7'h23, 5'd0,  5'd6,  5'd7,  3'd0, 7'd0,  32'd2047);       // SB max
        tbl[7] = mk(6'b100000, 7'h6F, 5'd2,  5'd0,  5'd0,  3'd0, 7'd0,  32'd1048574);    // JAL max

        apply_reset(3);
        @(negedge i_clk);
        check("rst_count", 32'(o_count), 32'h0);
        check("rst_valid", 32'(o_valid), 32'h0);
        check("rst_ready", 32'(o_ready), 32'h1);
        check("rst_instr", o_instr, 32'h0);

        // Fill to DEPTH with the consumer stalled, then a fifth request waits.
        send(addi);
        idle();
        @(negedge i_clk);
        check("addi_latency_valid", 32'(o_valid), 32'h1);
        check("addi_latency_instr", o_instr, 32'h00500093);
        send(add);
        send(sw);
        send(lui);
        idle();
        @(negedge i_clk);
        check("full_ready", 32'(o_ready), 32'h0);
        check("full_count", 32'(o_count), 32'd4);
        fork
            send(beq);
            begin
                repeat (3) @(negedge i_clk);
                pop_check("addi", 32'h00500093);
            end
        join
        idle();
        pop_check("add", 32'h002081B3);
        pop_check("sw",  32'h0020A423);
        pop_check("lui", 32'h123452B7);
        pop_check("beq", 32'hFE000EE3);
        send(jal);
        idle();
        pop_check("jal", 32'h008000EF);

        // Full, then drain with concurrent pushes holding occupancy steady.
        for (int i = 0; i < 4; i++) send(tbl[i]);
        idle();
        @(negedge i_clk);
        #1 i_ready = 1'b1;
        for (int i = 4; i < 8; i++) send(tbl[i]);
        idle();
        repeat (6) @(negedge i_clk);
        #1 i_ready = 1'b0;

        // Streaming from empty with the consumer always ready (pointer wrap).
        #1 i_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(tbl[7 - i]);
        idle();
        repeat (3) @(negedge i_clk);
        #1 i_ready = 1'b0;

        // Out-of-range / misaligned / zero-hot requests.
`ifdef ENC_CHECK_EN
        send(mk(6'b000010, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048));
        @(negedge i_clk);
        check("illegal_addi_err", 32'(o_err), 32'h1);
        check("illegal_addi_count", 32'(o_count), 32'h0);
        #1 i_valid = 1'b0;
        @(negedge i_clk);
        check("illegal_err_one_cycle", 32'(o_err), 32'h0);
        send(mk(6'b001000, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3));
        @(negedge i_clk);
        check("illegal_beq_err", 32'(o_err), 32'h1);
        #1 i_valid = 1'b0;
        send(mk(6'b000000, 7'h13, 5'd1, 5'd2, 5'd3, 3'd1, 7'd1, 32'd1));
        @(negedge i_clk);
        check("zero_hot_err", 32'(o_err), 32'h1);
        #1 i_valid = 1'b0;
        send(mk(6'b010000, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001001));
        idle();
`else
        send(mk(6'b000010, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048));
        send(mk(6'b001000, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3));
        send(mk(6'b000000, 7'h13, 5'd1, 5'd2, 5'd3, 3'd1, 7'd1, 32'd1));
        idle();
        check("no_err_default", 32'(o_err), 32'h0);
        pop_check("trunc_addi", 32'h80000093);
        pop_check("trunc_beq",  32'h00000163);
        pop_check("zero_hot",   32'h00000013);
`endif

        // Reset with three entries queued.
        for (int i = 0; i < 3; i++) send(tbl[i]);
        idle();
        @(negedge i_clk);
        check("pre_rst_count", 32'(o_count), 32'd3);
        #1 i_rst_n = 1'b0;
        @(negedge i_clk);
        check("mid_rst_count", 32'(o_count), 32'h0);
        check("mid_rst_valid", 32'(o_valid), 32'h0);
        check("mid_rst_err",   32'(o_err),   32'h0);
        check("mid_rst_ready", 32'(o_ready), 32'h1);
        #1 i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        n_checks++;
        $display("FAIL watchdog: got timeout required completion");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
